// File: rtl/pipo_load_arbiter.sv
// ---------------------------------------------------------------------------
// pipo_load_arbiter : round-robin arbiter sequencing loads into a shared
//                     parallel-in/parallel-out register, plus its reset.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipo_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic                    reg_rst,
    output logic                    reg_pl,
    output logic [WIDTH-1:0]        reg_di
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [PW-1:0]      ptr, ptr_n;
    logic [PW-1:0]      sel, sel_n;
    logic [3:0]         cnt, cnt_n;
    logic [NREQ-1:0]    gnt_n, ack_n;
    logic               busy_n, reg_rst_n, reg_pl_n;
    logic [WIDTH-1:0]   reg_di_n;

    logic [PW-1:0]      pick;
    logic               found;
    logic               do_release;

    // Rotating-priority scan starting at ptr; first asserted request wins.
    always_comb begin
        logic [PW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        sel_n      = sel;
        cnt_n      = cnt;
        gnt_n      = gnt;
        ack_n      = '0;
        busy_n     = busy;
        reg_rst_n  = reg_rst;
        reg_pl_n   = 1'b0;
        reg_di_n   = reg_di;
        do_release = 1'b0;

        case (state)
            ST_INIT: begin
                reg_rst_n = 1'b0;
                state_n   = ST_IDLE;
            end
            ST_IDLE: begin
                if (found) begin
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    sel_n       = pick;
                    reg_di_n    = req_data[int'(pick)*WIDTH +: WIDTH];
                    reg_pl_n    = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (HOLD_CYCLES > 0) begin
                    cnt_n   = 4'(HOLD_CYCLES - 1);
                    state_n = ST_HOLD;
                end else begin
                    do_release = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == 4'd0) begin
                    do_release = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase

        // Ack lands in the first IDLE cycle, so back-to-back grants are spaced by one idle cycle.
        if (do_release) begin
            gnt_n      = '0;
            ack_n[sel] = 1'b1;
            busy_n     = 1'b0;
            ptr_n      = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
            state_n    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_INIT;
            ptr     <= '0;
            sel     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            reg_rst <= 1'b1;
            reg_pl  <= 1'b0;
            reg_di  <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            sel     <= sel_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            ack     <= ack_n;
            busy    <= busy_n;
            reg_rst <= reg_rst_n;
            reg_pl  <= reg_pl_n;
            reg_di  <= reg_di_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipo_load_arbiter : directed bench for pipo_load_arbiter (HOLD=2 and HOLD=0).
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipo_load_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req, gnt, ack;
    logic [15:0] req_data;
    logic        busy, reg_rst, reg_pl;
    logic [3:0]  reg_di;
    logic [3:0]  q;

    logic [3:0]  req0, gnt0, ack0;
    logic [15:0] req_data0;
    logic        busy0, reg_rst0, reg_pl0;
    logic [3:0]  reg_di0;
    logic [3:0]  q0;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rr_do  [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0001};

    pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .busy(busy), .reg_rst(reg_rst),
        .reg_pl(reg_pl), .reg_di(reg_di)
    );

    pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .req_data(req_data0),
        .gnt(gnt0), .ack(ack0), .busy(busy0), .reg_rst(reg_rst0),
        .reg_pl(reg_pl0), .reg_di(reg_di0)
    );

    // Behavioural model of the shared load register each arbiter drives.
    always @(posedge clk) begin
        if (reg_rst)      q <= 4'b0000;
        else if (reg_pl)  q <= reg_di;
        if (reg_rst0)     q0 <= 4'b0000;
        else if (reg_pl0) q0 <= reg_di0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        req_data  = '0;
        req0      = '0;
        req_data0 = '0;

        // Reset and INIT
        repeat (3) step();
        check("rst_reg_rst", reg_rst, 1);
        check("rst_gnt",     gnt,     0);
        check("rst_ack",     ack,     0);
        check("rst_reg_pl",  reg_pl,  0);
        check("rst_busy",    busy,    0);
        check("rst_reg_di",  reg_di,  0);
        reset = 1'b1;
        check("init_reg_rst", reg_rst, 1);
        step();
        check("idle_reg_rst", reg_rst, 0);
        check("init_do",      q,       0);
        check("init_gnt",     gnt,     0);
        step();
        check("idle_gnt",    gnt,    0);
        check("idle_reg_pl", reg_pl, 0);

        // Single load, requester 0
        req           = 4'b0001;
        req_data[3:0] = 4'b1001;
        step();
        check("single_gnt",    gnt,    4'b0001);
        check("single_pl",     reg_pl, 1);
        check("single_busy",   busy,   1);
        check("single_reg_di", reg_di, 4'b1001);
        step();
        check("single_pl_off", reg_pl, 0);
        check("single_do",     q,      4'b1001);
        check("single_gnt_h1", gnt,    4'b0001);
        step();
        check("single_ack_early", ack, 0);
        check("single_gnt_h2",    gnt, 4'b0001);
        step();
        check("single_ack",      ack,  4'b0001);
        check("single_gnt_rel",  gnt,  0);
        check("single_busy_rel", busy, 0);
        req = 4'b0000;
        step();
        check("single_ack_off", ack, 0);
        check("single_gnt_off", gnt, 0);

        // Round-robin from a fresh pointer
        do_reset();
        req      = 4'b1111;
        req_data = 16'h4321;
        for (int g = 0; g < 5; g++) begin
            step();
            check("rr_gnt", gnt, rr_gnt[g]);
            check("rr_pl",  reg_pl, 1);
            step();
            check("rr_do",     q,      rr_do[g]);
            check("rr_pl_off", reg_pl, 0);
            step();
            step();
            check("rr_ack",      ack, rr_gnt[g]);
            check("rr_idle_gnt", gnt, 0);
        end
        req = 4'b0000;
        step();
        check("rr_end_gnt", gnt, 0);

        // Data change after capture (pointer now 1)
        req      = 4'b0010;
        req_data = 16'h0060;
        step();
        check("dchg_gnt",    gnt,    4'b0010);
        check("dchg_reg_di", reg_di, 4'b0110);
        step();
        check("dchg_do", q, 4'b0110);
        req_data[7:4] = 4'b1111;
        step();
        check("dchg_reg_di_hold", reg_di, 4'b0110);
        check("dchg_do_hold",     q,      4'b0110);
        step();
        check("dchg_ack", ack, 4'b0010);
        req = 4'b0000;
        step();
        check("dchg_reg_di_idle", reg_di, 4'b0110);
        check("dchg_do_idle",     q,      4'b0110);
        check("dchg_gnt_idle",    gnt,    0);

        // Withdrawn request (pointer now 2)
        req = 4'b0100;
        step();
        check("wd_gnt", gnt, 4'b0100);
        step();
        req = 4'b0000;
        step();
        check("wd_gnt_held", gnt, 4'b0100);
        step();
        check("wd_ack", ack, 4'b0100);
        step();
        check("wd_ack_off", ack, 0);
        check("wd_gnt_off", gnt, 0);

        // Async reset mid-HOLD (pointer now 3)
        req = 4'b1000;
        step();
        check("ar_gnt", gnt, 4'b1000);
        step();
        #2 reset = 1'b0;
        #1;
        check("ar_gnt_clr",  gnt,     0);
        check("ar_reg_rst",  reg_rst, 1);
        check("ar_busy",     busy,    0);
        check("ar_reg_pl",   reg_pl,  0);
        step();
        check("ar_no_ack1", ack, 0);
        step();
        check("ar_no_ack2", ack, 0);
        reset = 1'b1;
        step();
        check("ar_reg_rst_rel", reg_rst, 0);
        check("ar_no_ack3",     ack,     0);
        req = 4'b1001;
        step();
        check("ar_ptr_zero", gnt, 4'b0001);
        step();
        step();
        step();
        check("ar_ack0", ack, 4'b0001);
        req = 4'b0000;
        step();

        // HOLD_CYCLES = 0 instance
        req0      = 4'b0100;
        req_data0 = 16'h0A00;
        step();
        check("h0_gnt", gnt0,    4'b0100);
        check("h0_pl",  reg_pl0, 1);
        check("h0_ack_early", ack0, 0);
        step();
        check("h0_pl_off",  reg_pl0, 0);
        check("h0_ack",     ack0,    4'b0100);
        check("h0_gnt_rel", gnt0,    0);
        check("h0_do",      q0,      4'b1010);
        req0 = 4'b0000;
        step();
        check("h0_ack_off", ack0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
